// File: rtl/piso_pkg.sv
// Shared FSM state type and default width for the PISO serializer.
// Macro PISO_PARITY_EN adds the PARITY state to the enum.
package piso_pkg;

    localparam int PISO_DEFAULT_WIDTH = 8;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } piso_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } piso_state_t;
`endif

endpackage

// File: rtl/piso_serializer_parity_calc.sv
// Even-parity (XOR reduce) of a WIDTH-bit word; used only when PISO_PARITY_EN
// is defined.
module parity_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    assign parity = even_parity(data);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load and framing flags.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    // Counter must reach WIDTH when the parity slot follows the data bits.
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    piso_state_t      state_r;
    piso_state_t      state_next_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_shift_s;
    logic [CNT_W-1:0] cnt_r;
    logic             head_s;
    logic             data_last_s;
    logic             last_bit_s;
    logic             transfer_s;

    assign head_s        = (MSB_FIRST != 0) ? shreg_r[WIDTH-1] : shreg_r[0];
    assign shreg_shift_s = (MSB_FIRST != 0) ? {shreg_r[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg_r[WIDTH-1:1]};
    assign data_last_s   = (state_r == ST_SHIFT) && (cnt_r == LAST_IDX);
    assign transfer_s    = load_valid && load_ready;

`ifdef PISO_PARITY_EN
    logic par_s;
    logic par_r;

    parity_calc #(.WIDTH(WIDTH)) u_parity_calc (
        .data   (load_data),
        .parity (par_s)
    );

    assign last_bit_s = (state_r == ST_PARITY);

    // Parity of the captured word, held until the parity slot is sent.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_r <= 1'b0;
        end else if (transfer_s) begin
            par_r <= par_s;
        end
    end
`else
    assign last_bit_s = data_last_s;
`endif

    // Handshake and serial outputs, all decoded from registered state.
    always_comb begin
        load_ready  = en && ((state_r == ST_IDLE) || last_bit_s);
        busy        = (state_r != ST_IDLE);
        sout_valid  = busy;
        frame_start = busy && (cnt_r == CNT_ZERO);
        frame_end   = busy && last_bit_s;
        sout        = 1'b0;
        case (state_r)
            ST_SHIFT:  sout = head_s;
`ifdef PISO_PARITY_EN
            ST_PARITY: sout = par_r;
`endif
            default:   sout = 1'b0;
        endcase
    end

    // Next-state logic; only enabled cycles can move the FSM.
    always_comb begin
        state_next_s = state_r;
        if (en) begin
            case (state_r)
                ST_IDLE: begin
                    if (transfer_s) begin
                        state_next_s = ST_SHIFT;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (data_last_s) begin
`ifdef PISO_PARITY_EN
                        state_next_s = ST_PARITY;
`else
                        state_next_s = transfer_s ? ST_SHIFT : ST_IDLE;
`endif
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end
`ifdef PISO_PARITY_EN
                ST_PARITY: begin
                    state_next_s = transfer_s ? ST_SHIFT : ST_IDLE;
                end
`endif
                default: state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state register; reset is not gated by en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else if (en) begin
            state_r <= state_next_s;
        end
    end

    // Shift register and bit counter; a new capture overrides the shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
        end else if (en) begin
            if (transfer_s) begin
                shreg_r <= load_data;
                cnt_r   <= CNT_ZERO;
            end else if (state_next_s == ST_IDLE) begin
                shreg_r <= {WIDTH{1'b0}};
                cnt_r   <= CNT_ZERO;
            end else if (state_r == ST_SHIFT) begin
                shreg_r <= shreg_shift_s;
                cnt_r   <= cnt_r + CNT_ONE;
            end
        end
    end

endmodule
